approx_sweep_ctrl: RTL

- Exhaustive error-evaluation sequencer for one generated approximate circuit instance.
- Drives every input vector, one per cycle, into an exact and an approximate copy of the same function, which are instantiated outside this block.
- Compares the two outputs as unsigned integers against an error threshold and reports pass/fail, maximum error, failure count and the first failing vector.
- Used in on-chip and FPGA validation of XPAT-synthesised blocks such as the abs_diff family.

---
 rtl/approx_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/approx_sweep_ctrl.sv
// approx_sweep_ctrl: exhaustive exact-vs-approximate error sweep sequencer.
// Issues every NI-bit vector once to two external datapaths, compares their
// results LAT cycles later and accumulates max error, failure count and the
// first failing vector against a threshold captured when the sweep starts.
module approx_sweep_ctrl #(
  parameter int NI  = 4,
  parameter int NO  = 3,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NO-1:0] et,
  output logic [NI-1:0] vec,
  output logic          vec_valid,
  input  logic [NO-1:0] exact_out,
  input  logic [NO-1:0] approx_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NO-1:0] max_err,
  output logic [NI:0]   err_count,
  output logic          fail_seen,
  output logic [NI-1:0] first_fail_vec
);

  localparam logic [NI-1:0] VEC_LAST   = '1;
  localparam logic [NI:0]   COUNT_MAX  = {1'b1, {NI{1'b0}}};
  // With LAT=0 the DRAIN state is never entered, so this value is unused.
  localparam logic [2:0]    DRAIN_LAST = 3'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic start_accept;
  logic abort_accept;
  logic enter_done;
  logic vec_step;
  logic vec_stop;

  logic [2:0]    drain_cnt;
  logic [NO-1:0] et_cap;

  logic          eval_valid;
  logic [NI-1:0] eval_vec;
  logic [NO-1:0] err;
  logic [NO-1:0] max_next;
  logic          eval_fail;

  assign busy = (state == SWEEP) || (state == DRAIN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the control strobes that steer the datapath registers.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    abort_accept = 1'b0;
    enter_done   = 1'b0;
    vec_step     = 1'b0;
    vec_stop     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = SWEEP;
          start_accept = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_next   = IDLE;
          abort_accept = 1'b1;
          vec_stop     = 1'b1;
        end else if (vec == VEC_LAST) begin
          vec_stop = 1'b1;
          if (LAT == 0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          vec_step = 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_next   = IDLE;
          abort_accept = 1'b1;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector generator: restarts at zero on start, steps once per sweep cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec       <= '0;
      vec_valid <= 1'b0;
    end else if (start_accept) begin
      vec       <= '0;
      vec_valid <= 1'b1;
    end else if (vec_stop) begin
      vec_valid <= 1'b0;
    end else if (vec_step) begin
      vec <= vec + 1'b1;
    end
  end

  // Counts cycles spent in DRAIN so the last in-flight result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 1'b1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Tag pipeline: tracks which vector each datapath result belongs to.
  generate
    if (LAT == 0) begin : g_no_pipe
      assign eval_valid = vec_valid;
      assign eval_vec   = vec;
    end else begin : g_pipe
      logic          pipe_valid [LAT];
      logic [NI-1:0] pipe_vec   [LAT];

      // Shift {valid, vec} one stage per cycle; an abort drops everything in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_vec[i]   <= '0;
          end
        end else begin
          pipe_valid[0] <= vec_valid && !abort_accept;
          pipe_vec[0]   <= vec;
          for (int i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1] && !abort_accept;
            pipe_vec[i]   <= pipe_vec[i-1];
          end
        end
      end

      assign eval_valid = pipe_valid[LAT-1];
      assign eval_vec   = pipe_vec[LAT-1];
    end
  endgenerate

  // Absolute error of the emerging result and the running maximum it implies.
  always_comb begin
    err       = (exact_out >= approx_out) ? (exact_out - approx_out)
                                          : (approx_out - exact_out);
    eval_fail = eval_valid && (err > et_cap);
    max_next  = max_err;
    if (eval_valid && (err > max_err)) begin
      max_next = err;
    end
  end

  // Result accumulators: cleared on start, updated per valid tag, held in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      et_cap         <= '0;
      max_err        <= '0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (start_accept) begin
      et_cap         <= et;
      max_err        <= '0;
      err_count      <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else begin
      max_err <= max_next;
      if (eval_fail) begin
        if (err_count != COUNT_MAX) begin
          err_count <= err_count + 1'b1;
        end
        fail_seen <= 1'b1;
        if (!fail_seen) begin
          first_fail_vec <= eval_vec;
        end
      end
      if (enter_done) begin
        pass <= (max_next <= et_cap);
      end
    end
  end

endmodule
